// File: rtl/morse_stream_encoder_pkg.sv
// Shared types and helpers for the buffered Morse transmitter: FSM state
// encoding, default symbol codes and the unit-counter width rule.
package morse_stream_encoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MARK     = 3'd1,
    ST_SYM_GAP  = 3'd2,
    ST_CHAR_GAP = 3'd3,
    ST_WORD_GAP = 3'd4
  } state_e;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  // Unit counters must hold the longest duration of any state.
  function automatic int unit_width(input int a, input int b, input int c,
                                    input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/morse_stream_encoder_fifo.sv
// Synchronous character FIFO with flush; count and ready are registered so
// they reflect the state after each push/pop edge.
module morse_fifo
  import morse_stream_encoder_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ready_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             ready_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ready_q;
  assign do_pop  = pop_i & (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != FULL);
    end
  end

  // Storage carries no reset; only pointers and count are control state.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/morse_stream_encoder.sv
// Buffered Morse transmitter: characters queue in a FIFO and are serialised
// by a unit prescaler, a unit counter and a five-state FSM.
module morse_stream_encoder
  import morse_stream_encoder_pkg::*;
#(
  parameter int   CODE_WIDTH     = 8,
  parameter int   LEN_WIDTH      = 4,
  parameter int   UNIT_CYCLES    = 800_000,
  parameter int   DOT_UNITS      = 1,
  parameter int   DASH_UNITS     = 3,
  parameter int   SYM_GAP_UNITS  = 1,
  parameter int   CHAR_GAP_UNITS = 3,
  parameter int   WORD_GAP_UNITS = 7,
  parameter int   FIFO_DEPTH     = 4,
  parameter logic CODE_DOT       = SYM_DOT,
  parameter logic CODE_DASH      = SYM_DASH
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [CODE_WIDTH-1:0]         code_i,
  input  logic [LEN_WIDTH-1:0]          len_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic                          abort_i,
  output logic                          serial_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int EW = $clog2(CODE_WIDTH + 1);
  localparam int UW = unit_width(DOT_UNITS, DASH_UNITS, SYM_GAP_UNITS,
                                 CHAR_GAP_UNITS, WORD_GAP_UNITS);
  localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int FW = CODE_WIDTH + LEN_WIDTH;

  localparam logic [PW-1:0] PRESC_RELOAD = PW'(UNIT_CYCLES - 1);
  localparam logic [UW-1:0] U_DOT  = UW'(DOT_UNITS);
  localparam logic [UW-1:0] U_DASH = UW'(DASH_UNITS);
  localparam logic [UW-1:0] U_SYM  = UW'(SYM_GAP_UNITS);
  localparam logic [UW-1:0] U_CHAR = UW'(CHAR_GAP_UNITS);
  localparam logic [UW-1:0] U_WORD = UW'(WORD_GAP_UNITS);

  if (UNIT_CYCLES < 1 || DOT_UNITS < 1 || DASH_UNITS < 1 || SYM_GAP_UNITS < 1 ||
      CHAR_GAP_UNITS < 1 || WORD_GAP_UNITS < 1) begin : g_bad_units
    $error("morse_stream_encoder: every unit parameter must be >= 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("morse_stream_encoder: FIFO_DEPTH must be a power of two >= 2");
  end

  function automatic logic [UW-1:0] mark_units(input logic sym);
    return (sym == CODE_DASH) ? U_DASH : U_DOT;
  endfunction

  state_e                  state_q, state_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [UW-1:0]           unit_q, unit_d;
  logic [CODE_WIDTH-1:0]   shift_q, shift_d, shift_next;
  logic [EW-1:0]           elem_q, elem_d;
  logic [FW-1:0]           fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                    fifo_ready, fifo_push, fifo_pop, pop_req;
  logic [CODE_WIDTH-1:0]   head_code;
  logic [LEN_WIDTH-1:0]    head_len;
  logic [EW-1:0]           head_elems;
  logic                    rollover, expire;

  assign fifo_push = valid_i & fifo_ready & ~abort_i;
  assign fifo_pop  = pop_req & ~abort_i;

  morse_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (abort_i),
    .push_i  (fifo_push),
    .wdata_i ({len_i, code_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .ready_o (fifo_ready)
  );

  assign head_code  = fifo_rdata[CODE_WIDTH-1:0];
  assign head_len   = fifo_rdata[FW-1:CODE_WIDTH];
  assign shift_next = shift_q >> 1;
  assign rollover   = (presc_q == '0);
  assign expire     = rollover && (unit_q == UW'(1));

  always_comb begin
    if (32'(head_len) > 32'(CODE_WIDTH)) head_elems = EW'(CODE_WIDTH);
    else                                 head_elems = EW'(head_len);
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    unit_d  = unit_q;
    shift_d = shift_q;
    elem_d  = elem_q;
    pop_req = 1'b0;
    // Prescaler reloads on each rollover, so every state entry starts a fresh unit.
    if (state_q != ST_IDLE) begin
      presc_d = rollover ? PRESC_RELOAD : presc_q - 1'b1;
      if (rollover) unit_d = unit_q - 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          pop_req = 1'b1;
          shift_d = head_code;
          elem_d  = head_elems;
          presc_d = PRESC_RELOAD;
          if (head_elems == '0) begin
            state_d = ST_WORD_GAP;
            unit_d  = U_WORD;
          end else begin
            state_d = ST_MARK;
            unit_d  = mark_units(head_code[0]);
          end
        end
      end
      ST_MARK: begin
        if (expire) begin
          if (elem_q > EW'(1)) begin
            state_d = ST_SYM_GAP;
            unit_d  = U_SYM;
            elem_d  = elem_q - 1'b1;
          end else begin
            state_d = ST_CHAR_GAP;
            unit_d  = U_CHAR;
          end
        end
      end
      ST_SYM_GAP: begin
        if (expire) begin
          state_d = ST_MARK;
          shift_d = shift_next;
          unit_d  = mark_units(shift_next[0]);
        end
      end
      ST_CHAR_GAP, ST_WORD_GAP: begin
        if (expire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || abort_i) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      unit_q  <= '0;
      shift_q <= '0;
      elem_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      unit_q  <= unit_d;
      shift_q <= shift_d;
      elem_q  <= elem_d;
    end
  end

  assign serial_o     = (state_q == ST_MARK);
  assign busy_o       = (state_q != ST_IDLE);
  assign ready_o      = fifo_ready;
  assign fifo_count_o = fifo_count;

endmodule

// File: tb/tb_morse_stream_encoder.sv
// Scoreboard bench: stimulus predicts mark lengths, inter-mark spaces and busy
// spans from the Morse timing rules; a monitor measures the line and compares.
module tb_morse_stream_encoder;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rstn, valid, abort;
  logic [7:0] code;
  logic [3:0] len;
  logic       ready, serial, busy;
  logic [2:0] count;

  morse_stream_encoder #(
    .CODE_WIDTH (8), .LEN_WIDTH (4), .UNIT_CYCLES (U),
    .DOT_UNITS (1), .DASH_UNITS (3), .SYM_GAP_UNITS (1),
    .CHAR_GAP_UNITS (3), .WORD_GAP_UNITS (7), .FIFO_DEPTH (4)
  ) dut (
    .clk_i (clk), .rstn_i (rstn), .code_i (code), .len_i (len),
    .valid_i (valid), .ready_o (ready), .abort_i (abort),
    .serial_o (serial), .busy_o (busy), .fifo_count_o (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mark;
    int gap;
  } mark_t;

  mark_t exp_marks[$];
  int    exp_busy[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    pend = -1;
  bit    skip_hi = 0, skip_busy = 0, mon_en = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a character is n marks (dot U, dash 3U) with U spaces between
  // them and a 3U char gap; a word entry is 7U of space. A queued successor
  // follows after one extra idle cycle.
  task automatic model_push(input logic [7:0] c, input logic [3:0] l);
    int n, tot, m;
    mark_t e;
    n = (l > 4'd8) ? 8 : int'(l);
    if (n == 0) begin
      exp_busy.push_back(7 * U);
      if (pend >= 0) pend = pend + 7 * U + 1;
    end else begin
      tot = 0;
      for (int i = 0; i < n; i++) begin
        m = c[i] ? 3 * U : U;
        e.mark = m;
        e.gap = (i == 0) ? pend : U;
        exp_marks.push_back(e);
        tot += m;
      end
      tot += (n - 1) * U + 3 * U;
      exp_busy.push_back(tot);
      pend = 3 * U + 1;
    end
  endtask

  // Entered and left at #1 after a rising edge; consecutive calls keep valid high.
  task automatic push1(input logic [7:0] c, input logic [3:0] l, input bit accept);
    valid = 1'b1;
    code = c;
    len = l;
    @(posedge clk);
    #1;
    valid = 1'b0;
    if (accept) model_push(c, l);
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while ((exp_marks.size() != 0 || exp_busy.size() != 0 || busy) && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, " drained in time"}, int'(cyc < 3000), 1);
    repeat (3) @(posedge clk);
    #1;
    check({name, " marks left"}, exp_marks.size(), 0);
    exp_marks.delete();
    exp_busy.delete();
    pend = -1;
  endtask

  // Monitor: run-length measurement of serial_o and busy_o on the falling edge.
  int    hi_run = 0, lo_run = 0, last_lo = 0, busy_run = 0;
  logic  prev_ser = 1'b0, prev_busy = 1'b0;
  mark_t mon_e;
  int    mon_b;

  always @(negedge clk) begin
    if (!mon_en) begin
      hi_run = 0; lo_run = 0; busy_run = 0; prev_ser = 1'b0; prev_busy = 1'b0;
    end else begin
      if (serial) begin
        if (!prev_ser) begin
          last_lo = lo_run;
          hi_run = 0;
        end
        hi_run++;
      end else begin
        if (prev_ser) begin
          lo_run = 0;
          if (skip_hi) skip_hi = 0;
          else if (exp_marks.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected mark: got length %0d, expected none (t=%0t)", hi_run, $time);
          end else begin
            mon_e = exp_marks.pop_front();
            check("mark length", hi_run, mon_e.mark);
            if (mon_e.gap >= 0) check("space before mark", last_lo, mon_e.gap);
          end
        end
        lo_run++;
      end
      if (busy) begin
        if (!prev_busy) busy_run = 0;
        busy_run++;
      end else if (prev_busy) begin
        if (skip_busy) skip_busy = 0;
        else if (exp_busy.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected busy span: got %0d, expected none (t=%0t)", busy_run, $time);
        end else begin
          mon_b = exp_busy.pop_front();
          check("busy span", busy_run, mon_b);
        end
      end
      prev_ser = serial;
      prev_busy = busy;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] rc;
  logic [3:0] rl;
  int         nb;

  initial begin
    rstn = 1'b0; valid = 1'b0; abort = 1'b0; code = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset serial", int'(serial), 0);
    check("reset busy", int'(busy), 0);
    check("reset ready", int'(ready), 1);
    check("reset count", int'(count), 0);
    rstn = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // 'A' with push-to-mark latency
    push1(8'b10, 4'd2, 1'b1);
    check("A count after push", int'(count), 1);
    check("A serial before pop", int'(serial), 0);
    @(posedge clk);
    #1;
    check("A serial after pop", int'(serial), 1);
    check("A busy after pop", int'(busy), 1);
    check("A count after pop", int'(count), 0);
    wait_idle("A");

    push1(8'h5A, 4'd0, 1'b1);
    wait_idle("word gap");

    push1(8'h00, 4'd1, 1'b1);
    push1(8'h00, 4'd1, 1'b1);
    wait_idle("E E");

    push1(8'hFF, 4'd15, 1'b1);
    wait_idle("clamp");

    // Backpressure: four queue behind the character in flight, fifth dropped.
    push1(8'b10, 4'd2, 1'b1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      rc = 8'($urandom);
      rl = 4'($urandom_range(1, 3));
      push1(rc, rl, k < 4);
      check("backpressure count", int'(count), (k < 4) ? k + 1 : 4);
      check("backpressure ready", int'(ready), (k < 3) ? 1 : 0);
    end
    wait_idle("backpressure");

    for (int b = 0; b < 8; b++) begin
      nb = $urandom_range(1, 5);
      for (int k = 0; k < nb; k++) begin
        rc = 8'($urandom);
        rl = 4'($urandom_range(0, 10));
        push1(rc, rl, 1'b1);
      end
      wait_idle("random burst");
    end

    // Abort mid-dash, then the same with a one-cycle reset.
    for (int s = 0; s < 2; s++) begin
      push1(8'h01, 4'd3, 1'b0);
      push1(8'h03, 4'd2, 1'b0);
      push1(8'h00, 4'd1, 1'b0);
      check("queued before stop", int'(count), 2);
      repeat (2) @(posedge clk);
      #1;
      check("mid dash serial", int'(serial), 1);
      skip_hi = 1'b1;
      skip_busy = 1'b1;
      if (s == 0) abort = 1'b1;
      else rstn = 1'b0;
      valid = 1'b1;
      code = 8'h02;
      len = 4'd1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      rstn = 1'b1;
      valid = 1'b0;
      check(s == 0 ? "abort serial" : "reset serial", int'(serial), 0);
      check(s == 0 ? "abort busy" : "reset busy", int'(busy), 0);
      check(s == 0 ? "abort count" : "reset count", int'(count), 0);
      check(s == 0 ? "abort ready" : "reset ready", int'(ready), 1);
      repeat (60) @(posedge clk);
      #1;
      check(s == 0 ? "after abort busy" : "after reset busy", int'(busy), 0);
      check(s == 0 ? "after abort count" : "after reset count", int'(count), 0);
      skip_hi = 1'b0;
      skip_busy = 1'b0;
      pend = -1;
    end

    push1(8'h00, 4'd1, 1'b1);
    wait_idle("after stop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
